row_read_scheduler: RTL
=======================

# row_read_scheduler

Sequences PE reads out of the row buffer for one output feature map. It walks channel × kernel-row × kernel-column for each output row and drives the row buffer read interface (R_C_Channel, pe_ctrl_ready). It tracks one-cycle RAM read latency to mark returning data beats, and pulses pe_buffer_switch to hand the row buffer to the next row. It sits between the row buffer controller and the PE array input.

## Interface
Parameters:
- K, 3, kernel height/width (R, C offsets 0..K-1)
- C, 256, input channels per output row
- OUT_ROWS, 56, output rows per feature map
- ROW_WIDTH, 10, width of each R_C_Channel field and of row_idx

Ports:
- clk  in  1  clock; everything is rising-edge
- rstn  in  1  reset; one clock, reset is asynchronous and active-low
- start  in  1  begin one feature map; sampled only in IDLE
- row_buffer_data_valid  in  1  row buffer holds a complete, readable row set
- pe_stall  in  1  PE input backpressure
- R_C_Channel  out  [2:0][ROW_WIDTH]  [0]=kernel row, [1]=kernel col, [2]=channel (RAM address)
- pe_ctrl_ready  out  1  read issued this cycle when high together with row_buffer_data_valid
- pe_buffer_switch  out  1  one-cycle pulse: current row finished
- pe_data_valid  out  1  row buffer data on pe_ctrl_data is a valid beat
- pe_data_last  out  1  marks the final beat (C*K*K-th) of a row
- row_idx  out  ROW_WIDTH  current output row, 0..OUT_ROWS-1
- busy  out  1  high outside IDLE
- fm_done  out  1  one-cycle pulse after the last row's switch

## Operation
- States: IDLE, WAIT_VALID, ISSUE, DRAIN, SWITCH.
- IDLE: when start=1, go to WAIT_VALID with row_idx=0. Otherwise stay in IDLE.
- WAIT_VALID: when row_buffer_data_valid=1, go to ISSUE. Otherwise stay.
- ISSUE: pe_ctrl_ready = !pe_stall. A read fires when pe_ctrl_ready && row_buffer_data_valid.
  - On each fire, R_C_Channel takes the next tuple. The column counter is innermost, then row, then channel: (r,c,ch) = (0,0,0),(0,1,0),…,(K-1,K-1,0),(0,0,1),…,(K-1,K-1,C-1).
  - The fire on (K-1,K-1,C-1) moves the state to DRAIN.
  - No fire means the counters and R_C_Channel hold.
- DRAIN: one cycle with no issue; the last beat returns. Then go to SWITCH.
- SWITCH: pe_buffer_switch=1 for exactly one cycle, and the channel/row/col counters clear.
  - If row_idx==OUT_ROWS-1: row_idx←0, fm_done pulses the following cycle, go to IDLE.
  - Otherwise: row_idx+1, go to WAIT_VALID.
- R_C_Channel is registered and holds its last issued value outside ISSUE. The row buffer's column/row mux uses the previous-cycle value, so it must not glitch.
- start while busy=1 is ignored.
- row_buffer_data_valid dropping during ISSUE only pauses firing. The sequence resumes from the held tuple.

## Timing
- Reset (async) values: state=IDLE, R_C_Channel=0, pe_ctrl_ready=0, pe_buffer_switch=0, pe_data_valid=0, pe_data_last=0, row_idx=0, busy=0, fm_done=0. Reset mid-row abandons the row without a switch pulse.
- pe_ctrl_ready is combinational from state and pe_stall. All other outputs are registered.
- pe_data_valid = fire delayed 1 cycle. pe_data_last = (fire on the final tuple) delayed 1 cycle, so it coincides with DRAIN.
- pe_stall has a one-beat slack: a beat fired in the cycle before stall rises still returns. The PE side must absorb it.
- Minimum row period without stall: 1 (WAIT_VALID) + C*K*K (ISSUE) + 1 (DRAIN) + 1 (SWITCH) cycles.
- The row buffer drops row_buffer_data_valid the cycle after pe_buffer_switch. WAIT_VALID therefore never sees a stale valid.
- Counters: channel counter is ROW_WIDTH bits and compares against C-1. Row/col counters compare against K-1. None of them wrap except through SWITCH.

## Test plan
Bench configuration for all scenarios: K=3, C=2, OUT_ROWS=3.
- Reset check: assert rstn=0 mid-ISSUE -> all outputs read 0 immediately, state is IDLE. A later start restarts at row_idx=0, tuple (0,0,0).
- Single row, no stall: start, valid high -> 18 consecutive fires in order (0,0,0)…(2,2,1). pe_data_valid goes high 18 cycles, one cycle late. pe_data_last is high on beat 18. pe_buffer_switch pulses 2 cycles after the last fire.
- Stall: pe_stall=1 for 3 cycles after the 5th fire -> pe_ctrl_ready=0 and R_C_Channel holds (1,1,0). Exactly one extra pe_data_valid beat follows stall rise. Total is still 18 beats; the row completes 3 cycles later than unstalled.
- Late valid: hold row_buffer_data_valid low 10 cycles after the switch -> no fire and pe_ctrl_ready=1 never coincides with valid. Row 1 starts the cycle after valid rises.
- Full map: 3 rows -> 3 switch pulses, row_idx 0→1→2→0, and fm_done pulses once, one cycle after the third switch. busy falls with fm_done. A start pulse in the middle of row 1 has no effect.
- Valid drop mid-row: deassert row_buffer_data_valid for 2 cycles at tuple (0,2,1) -> firing pauses and resumes at (0,2,1). No tuple is skipped or repeated.

Source files
------------

// File: rtl/row_read_scheduler.sv
// rtl/row_read_scheduler.sv - row buffer read sequencer feeding the PE array for one output feature map
//
// Walks channel x kernel-row x kernel-column (column innermost) for every
// output row, issues one row buffer read per accepted cycle, marks the beats
// that come back one cycle later, and hands the row buffer over with a
// one-cycle switch pulse when a row is complete.
//
// Ports:
//   clk                    clock, rising edge
//   rstn                   asynchronous active-low reset
//   start                  begin one feature map (only honoured in IDLE)
//   row_buffer_data_valid  row buffer holds a complete readable row set
//   pe_stall               PE input backpressure
//   R_C_Channel            [0]=kernel row, [1]=kernel col, [2]=channel (RAM address)
//   pe_ctrl_ready          read request; a read fires with row_buffer_data_valid
//   pe_buffer_switch       one-cycle pulse: current row finished
//   pe_data_valid          row buffer data beat is valid this cycle
//   pe_data_last           final beat of the row
//   row_idx                current output row
//   busy                   high outside IDLE
//   fm_done                one-cycle pulse after the last row's switch

module row_read_scheduler #(
  parameter int K         = 3,
  parameter int C         = 256,
  parameter int OUT_ROWS  = 56,
  parameter int ROW_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic                            row_buffer_data_valid,
  input  logic                            pe_stall,
  output logic [2:0][ROW_WIDTH-1:0]       R_C_Channel,
  output logic                            pe_ctrl_ready,
  output logic                            pe_buffer_switch,
  output logic                            pe_data_valid,
  output logic                            pe_data_last,
  output logic [ROW_WIDTH-1:0]            row_idx,
  output logic                            busy,
  output logic                            fm_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VALID,
    S_ISSUE,
    S_DRAIN,
    S_SWITCH
  } state_t;

  localparam logic [ROW_WIDTH-1:0] K_LAST   = ROW_WIDTH'(K - 1);
  localparam logic [ROW_WIDTH-1:0] C_LAST   = ROW_WIDTH'(C - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(OUT_ROWS - 1);
  localparam logic [ROW_WIDTH-1:0] ONE      = ROW_WIDTH'(1);

  state_t state_q;
  state_t state_d;

  // Counters hold the tuple that the next fire will issue.
  logic [ROW_WIDTH-1:0] krow_cnt;
  logic [ROW_WIDTH-1:0] kcol_cnt;
  logic [ROW_WIDTH-1:0] ch_cnt;

  logic fire;
  logic last_tuple;
  logic last_row;

  assign last_tuple = (krow_cnt == K_LAST) && (kcol_cnt == K_LAST) && (ch_cnt == C_LAST);
  assign last_row   = (row_idx == ROW_LAST);

  always_comb begin
    state_d       = state_q;
    pe_ctrl_ready = 1'b0;
    fire          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        if (row_buffer_data_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        pe_ctrl_ready = !pe_stall;
        fire          = !pe_stall && row_buffer_data_valid;
        if (fire && last_tuple) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_SWITCH;
      end
      S_SWITCH: begin
        state_d = last_row ? S_IDLE : S_WAIT_VALID;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Tuple counters and the registered read address. The address only moves
  // on a fire so the row buffer's column/row mux never sees a glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      krow_cnt    <= '0;
      kcol_cnt    <= '0;
      ch_cnt      <= '0;
      R_C_Channel <= '0;
    end else if (state_q == S_SWITCH || (state_q == S_IDLE && start)) begin
      krow_cnt <= '0;
      kcol_cnt <= '0;
      ch_cnt   <= '0;
    end else if (fire) begin
      R_C_Channel[0] <= krow_cnt;
      R_C_Channel[1] <= kcol_cnt;
      R_C_Channel[2] <= ch_cnt;
      // The final tuple leaves the counters parked; SWITCH clears them.
      if (!last_tuple) begin
        if (kcol_cnt == K_LAST) begin
          kcol_cnt <= '0;
          if (krow_cnt == K_LAST) begin
            krow_cnt <= '0;
            ch_cnt   <= ch_cnt + ONE;
          end else begin
            krow_cnt <= krow_cnt + ONE;
          end
        end else begin
          kcol_cnt <= kcol_cnt + ONE;
        end
      end
    end
  end

  // Registered status outputs. Beat flags trail the fire by the one-cycle
  // RAM read latency, so the last beat lands in DRAIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pe_data_valid    <= 1'b0;
      pe_data_last     <= 1'b0;
      pe_buffer_switch <= 1'b0;
      fm_done          <= 1'b0;
      busy             <= 1'b0;
      row_idx          <= '0;
    end else begin
      pe_data_valid    <= fire;
      pe_data_last     <= fire && last_tuple;
      pe_buffer_switch <= (state_d == S_SWITCH);
      fm_done          <= (state_q == S_SWITCH) && last_row;
      busy             <= (state_d != S_IDLE);
      if (state_q == S_IDLE && start) begin
        row_idx <= '0;
      end else if (state_q == S_SWITCH) begin
        row_idx <= last_row ? '0 : row_idx + ONE;
      end
    end
  end

endmodule
